// File: rtl/acia_host_if.sv
// acia_host_if: signal bundle between acia_host and its surroundings.
//
// Groups two sets of signals:
//   - the 6850 CPU-side register bus (n_rd, n_wr, regSel, data in/out, n_int);
//   - the byte streams (tx valid/ready, rx valid/ready) and init_done.
//
// Modports:
//   master : the acia_host side. It drives the UART strobes, tx_ready, the
//            rx stream and init_done.
//   slave  : the UART instance plus the stream clients.
interface acia_host_if;
  logic       acia_n_rd;
  logic       acia_n_wr;
  logic       acia_regSel;
  logic [7:0] acia_wdata;
  logic [7:0] acia_rdata;
  logic       acia_n_int;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_done;

  modport master (
    output acia_n_rd, acia_n_wr, acia_regSel, acia_wdata,
    output tx_ready, rx_data, rx_valid, init_done,
    input  acia_rdata, acia_n_int, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  acia_n_rd, acia_n_wr, acia_regSel, acia_wdata,
    input  tx_ready, rx_data, rx_valid, init_done,
    output acia_rdata, acia_n_int, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/acia_host.sv
// acia_host: bus master for the CPU-side register port of a 6850-compatible
// UART. It lets on-chip logic use the UART through byte-wide valid/ready
// streams instead of a Z80.
//
// Ports:
//   clk   - system clock (the UART's clock); all logic uses the rising edge.
//   reset - synchronous, active-high reset.
//   bus   - acia_host_if.master, which carries:
//             - the UART strobes, regSel and data in/out, and n_int;
//             - the tx/rx streams;
//             - init_done.
//
// Every register access uses one shared bus cycle:
//   SETUP  (SETUP_CYCLES)  : address and data driven, strobes high.
//   STROBE (STROBE_CYCLES) : one strobe low. Read data is sampled on the last
//                            strobe cycle.
//   HOLD   (1 cycle)       : strobes high, address and data unchanged.
//
// Optional feature, macro ACIA_HOST_IRQ_EN:
//   - RUN_CTRL bit 7 is forced to 1.
//   - acia_n_int is synchronised.
//   - IDLE waits for an interrupt or for pending tx data instead of polling
//     continuously, and no poll gap is inserted.
//   With the macro undefined, acia_n_int is ignored.
module acia_host #(
  parameter int         SETUP_CYCLES  = 1,
  parameter int         STROBE_CYCLES = 4,
  parameter logic [7:0] INIT_CTRL     = 8'h95,
  parameter logic [7:0] RUN_CTRL      = 8'h16,
  parameter int         POLL_GAP      = 2
) (
  input  logic        clk,
  input  logic        reset,
  acia_host_if.master bus
);

  typedef enum logic [2:0] {
    INIT_RST, INIT_CFG, IDLE, STAT_RD, DECIDE, DATA_RD, DATA_WR, GAP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tx_pri_q;      // 1: tx wins the next tie, 0: rx wins
  logic       init_done_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic [7:0] status_q;
  logic [7:0] wbyte_q;
  logic       start_poll;

`ifdef ACIA_HOST_IRQ_EN
  localparam logic [7:0] RUN_WORD = RUN_CTRL | 8'h80;
  localparam bit         USE_GAP  = 1'b0;

  logic n_int_s1, n_int_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_int_s1 <= 1'b1;
      n_int_s2 <= 1'b1;
    end else begin
      n_int_s1 <= bus.acia_n_int;
      n_int_s2 <= n_int_s1;
    end
  end

  assign start_poll = ~n_int_s2 | bus.tx_valid;
`else
  localparam logic [7:0] RUN_WORD = RUN_CTRL;
  localparam bit         USE_GAP  = (POLL_GAP > 0);

  logic unused_n_int;
  assign unused_n_int = bus.acia_n_int;
  assign start_poll   = 1'b1;
`endif

  logic bus_state, wr_state, strobe_on, setup_end, strobe_end;
  logic rx_ok, tx_ok, rx_win, tx_win;

  assign bus_state  = (state_q == INIT_RST) || (state_q == INIT_CFG) ||
                      (state_q == STAT_RD)  || (state_q == DATA_RD)  ||
                      (state_q == DATA_WR);
  assign wr_state   = (state_q == INIT_RST) || (state_q == INIT_CFG) ||
                      (state_q == DATA_WR);
  assign strobe_on  = bus_state && (phase_q == PH_STROBE);
  assign setup_end  = (phase_q == PH_SETUP)  && (cnt_q == 8'(SETUP_CYCLES - 1));
  assign strobe_end = (phase_q == PH_STROBE) && (cnt_q == 8'(STROBE_CYCLES - 1));

  // Arbitration. On a tie, the direction that was not served last wins.
  assign rx_ok  = status_q[0] & ~rx_valid_q;
  assign tx_ok  = status_q[1] & bus.tx_valid;
  assign rx_win = rx_ok & (~tx_ok | ~tx_pri_q);
  assign tx_win = tx_ok & ~rx_win;

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT_RST;
      phase_q <= PH_SETUP;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (bus_state) begin
      case (phase_q)
        PH_SETUP: begin
          if (setup_end) begin
            phase_d = PH_STROBE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PH_STROBE: begin
          if (strobe_end) begin
            phase_d = PH_HOLD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          phase_d = PH_SETUP;
          cnt_d   = 8'd0;
          case (state_q)
            INIT_RST: state_d = INIT_CFG;
            INIT_CFG: state_d = IDLE;
            STAT_RD:  state_d = DECIDE;
            default:  state_d = IDLE;
          endcase
        end
      endcase
    end else begin
      phase_d = PH_SETUP;
      case (state_q)
        IDLE: begin
          cnt_d = 8'd0;
          if (start_poll) state_d = STAT_RD;
        end
        DECIDE: begin
          cnt_d = 8'd0;
          if (rx_win)       state_d = DATA_RD;
          else if (tx_win)  state_d = DATA_WR;
          else if (USE_GAP) state_d = GAP;
          else              state_d = IDLE;
        end
        default: begin
          if (cnt_q == 8'(POLL_GAP - 1)) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Bus and stream outputs. wdata shows zero while reset is held, then the
  // init word from cycle 0 so it is already valid during the first SETUP.
  always_comb begin
    bus.acia_n_wr   = ~(strobe_on & wr_state);
    bus.acia_n_rd   = ~(strobe_on & ~wr_state);
    bus.acia_regSel = (state_q == DATA_RD) || (state_q == DATA_WR);
    bus.acia_wdata  = 8'h00;
    if (!reset) begin
      case (state_q)
        INIT_RST: bus.acia_wdata = INIT_CTRL;
        INIT_CFG: bus.acia_wdata = RUN_WORD;
        DATA_WR:  bus.acia_wdata = wbyte_q;
        default:  bus.acia_wdata = 8'h00;
      endcase
    end
    bus.tx_ready  = (state_q == DECIDE) && tx_win;
    bus.rx_valid  = rx_valid_q;
    bus.rx_data   = rx_data_q;
    bus.init_done = init_done_q;
  end

  // Stream side and priority tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      tx_pri_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      if ((state_q == DATA_RD) && strobe_end) begin
        rx_data_q  <= bus.acia_rdata;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (state_q == DECIDE) begin
        if (rx_win)      tx_pri_q <= 1'b1;
        else if (tx_win) tx_pri_q <= 1'b0;
      end
      if ((state_q == INIT_CFG) && (phase_q == PH_HOLD)) init_done_q <= 1'b1;
    end
  end

  // Data captures. These are only consumed after the state that fills them.
  always_ff @(posedge clk) begin
    if ((state_q == STAT_RD) && strobe_end) status_q <= bus.acia_rdata;
    if (bus.tx_ready) wbyte_q <= bus.tx_data;
  end

endmodule

// File: tb/tb_acia_host.sv
`timescale 1ns/1ps
module tb_acia_host;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  acia_host_if bus();
  acia_host dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef ACIA_HOST_IRQ_EN
  localparam logic [7:0] RUN_EXP = 8'h96;
`else
  localparam logic [7:0] RUN_EXP = 8'h16;
`endif

  // UART register-side model: rx FIFO, tx-empty flag, write log.
  logic [7:0] rx_mem [0:255];
  int         rx_tail = 0;
  int         rx_head = 0;
  logic       tx_bit = 1'b0;
  logic       wr_sel  [0:255];
  logic [7:0] wr_data [0:255];
  int         wr_cnt = 0;
  logic       ev_dir  [0:255];   // 0 = data read, 1 = data write
  logic [7:0] ev_byte [0:255];
  int         ev_cnt = 0;
  logic       prev_n_rd = 1'b1, prev_n_wr = 1'b1, prev_sel = 1'b0;
  logic [7:0] prev_wdata = 8'h00;

  assign bus.acia_rdata = bus.acia_regSel ? rx_mem[rx_head[7:0]]
                                          : {6'b0, tx_bit, (rx_head != rx_tail)};
  assign bus.acia_n_int = (rx_head == rx_tail);

  always @(posedge clk) begin
    if (!prev_n_wr && bus.acia_n_wr) begin
      wr_sel[wr_cnt[7:0]]  <= prev_sel;
      wr_data[wr_cnt[7:0]] <= prev_wdata;
      wr_cnt <= wr_cnt + 1;
      if (prev_sel) begin
        ev_dir[ev_cnt[7:0]]  <= 1'b1;
        ev_byte[ev_cnt[7:0]] <= prev_wdata;
        ev_cnt <= ev_cnt + 1;
      end
    end else if (!prev_n_rd && bus.acia_n_rd && prev_sel) begin
      ev_dir[ev_cnt[7:0]]  <= 1'b0;
      ev_byte[ev_cnt[7:0]] <= rx_mem[rx_head[7:0]];
      ev_cnt  <= ev_cnt + 1;
      rx_head <= rx_head + 1;
    end
    prev_n_rd  <= bus.acia_n_rd;
    prev_n_wr  <= bus.acia_n_wr;
    prev_sel   <= bus.acia_regSel;
    prev_wdata <= bus.acia_wdata;
  end

  // Bus-rule monitor: never both strobes, no address/data change under a strobe.
  int         viol = 0;
  int         strobe_cnt = 0;
  logic       strb_prev = 1'b0;
  logic       sel_prev = 1'b0;
  logic [7:0] wd_prev = 8'h00;
  always @(negedge clk) begin
    logic strb;
    logic bad;
    strb = !bus.acia_n_rd || !bus.acia_n_wr;
    bad  = (!bus.acia_n_rd && !bus.acia_n_wr) ||
           (strb && strb_prev && ((bus.acia_regSel != sel_prev) || (bus.acia_wdata != wd_prev)));
    if (bad) viol <= viol + 1;
    if (strb) strobe_cnt <= strobe_cnt + 1;
    strb_prev <= strb;
    sel_prev  <= bus.acia_regSel;
    wd_prev   <= bus.acia_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_tail[7:0]] = b;
    rx_tail++;
  endtask

  // Called at posedge+1 with reset high. Releases reset and follows cycles 0..12.
  task automatic release_and_check_init(input string tag);
    int base;
    logic exp_low;
    base = wr_cnt;
    reset = 1'b0;
    #1;
    for (int c = 0; c <= 12; c++) begin
      exp_low = (c < 12) && ((c % 6) >= 1) && ((c % 6) <= 4);
      check($sformatf("%s_nwr_c%0d", tag, c), {31'b0, bus.acia_n_wr}, {31'b0, !exp_low});
      check($sformatf("%s_nrd_c%0d", tag, c), {31'b0, bus.acia_n_rd}, 32'd1);
      if (c == 3)  check({tag, "_wdata_init"}, {24'b0, bus.acia_wdata}, 32'h95);
      if (c == 9)  check({tag, "_wdata_run"},  {24'b0, bus.acia_wdata}, {24'b0, RUN_EXP});
      if (c == 11) check({tag, "_done_c11"}, {31'b0, bus.init_done}, 32'd0);
      if (c == 12) check({tag, "_done_c12"}, {31'b0, bus.init_done}, 32'd1);
      tick();
    end
    check({tag, "_wr_count"}, wr_cnt - base, 32'd2);
    check({tag, "_wr0"}, {23'b0, wr_sel[base[7:0]], wr_data[base[7:0]]}, 32'h095);
    check({tag, "_wr1"}, {23'b0, wr_sel[8'(base + 1)], wr_data[8'(base + 1)]}, {24'b0, RUN_EXP});
  endtask

  // Randomised phase state.
  logic [7:0] exp_rx [$];
  logic [7:0] exp_tx [$];
  logic       tx_pend = 1'b0;
  logic       tx_hs = 1'b0;
  int         wr_chk = 0;

  task automatic rand_step(input bit drain);
    logic [7:0] b;
    if (tx_hs) begin
      exp_tx.push_back(bus.tx_data);
      tx_pend = 1'b0;
      tx_hs = 1'b0;
    end
    if (!drain) begin
      if (!tx_pend && $urandom_range(3) == 0) begin
        tx_pend = 1'b1;
        bus.tx_data = 8'($urandom);
      end
      bus.tx_valid = tx_pend && ($urandom_range(3) != 0);
      bus.rx_ready = ($urandom_range(2) != 0);
      tx_bit = ($urandom_range(7) != 0);
      if ($urandom_range(11) == 0 && (rx_tail - rx_head) < 20) begin
        b = 8'($urandom);
        push_rx(b);
        exp_rx.push_back(b);
      end
    end else begin
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b1;
      tx_bit = 1'b1;
    end
    #2;
    if (bus.tx_valid && bus.tx_ready) tx_hs = 1'b1;
    if (bus.rx_valid && bus.rx_ready) begin
      if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else check("rx_byte", {24'b0, bus.rx_data}, {24'b0, exp_rx.pop_front()});
    end
    while (wr_chk < wr_cnt) begin
      if (wr_sel[wr_chk[7:0]]) begin
        if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else check("tx_byte", {24'b0, wr_data[wr_chk[7:0]]}, {24'b0, exp_tx.pop_front()});
      end
      wr_chk++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   k;
    int   base;
    logic seen;
    int   idx;

    bus.tx_data  = 8'h41;
    bus.tx_valid = 1'b1;
    bus.rx_ready = 1'b0;
    tx_bit = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_n_rd",   {31'b0, bus.acia_n_rd},   32'd1);
    check("rst_n_wr",   {31'b0, bus.acia_n_wr},   32'd1);
    check("rst_regsel", {31'b0, bus.acia_regSel}, 32'd0);
    check("rst_wdata",  {24'b0, bus.acia_wdata},  32'd0);
    check("rst_tx_ready", {31'b0, bus.tx_ready},  32'd0);
    check("rst_rx_valid", {31'b0, bus.rx_valid},  32'd0);
    check("rst_rx_data",  {24'b0, bus.rx_data},   32'd0);
    check("rst_init_done", {31'b0, bus.init_done}, 32'd0);

    // Init sequence, with a tx byte already waiting for the first poll
    release_and_check_init("init");

    // Now in cycle 13; IDLE was cycle 12, so DECIDE falls at cycle 19
    seen = 1'b0;
    for (int c = 13; c <= 26; c++) begin
      if (seen) bus.tx_valid = 1'b0;
      check($sformatf("tx_ready_c%0d", c), {31'b0, bus.tx_ready}, {31'b0, (c == 19)});
      if (bus.tx_ready) seen = 1'b1;
      tick();
    end
    check("tx_write", {23'b0, wr_sel[8'(wr_cnt - 1)], wr_data[8'(wr_cnt - 1)]}, 32'h141);
    bus.tx_valid = 1'b0;
    tx_bit = 1'b0;

    // Receive with back-pressure
    base = rx_head;
    push_rx(8'h5A);
    push_rx(8'h33);
    k = 0;
    while (!bus.rx_valid && k < 200) begin tick(); k++; end
    check("rx1_timeout", {31'b0, bus.rx_valid}, 32'd1);
    check("rx1_data", {24'b0, bus.rx_data}, 32'h5A);
    repeat (60) tick();
    check("rx_hold_valid", {31'b0, bus.rx_valid}, 32'd1);
    check("rx_hold_data", {24'b0, bus.rx_data}, 32'h5A);
    check("rx_hold_reads", rx_head - base, 32'd1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("rx_clear", {31'b0, bus.rx_valid}, 32'd0);
    k = 0;
    while (!bus.rx_valid && k < 200) begin tick(); k++; end
    check("rx2_timeout", {31'b0, bus.rx_valid}, 32'd1);
    check("rx2_data", {24'b0, bus.rx_data}, 32'h33);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;

    // Reset in the middle of a data read strobe
    push_rx(8'hEE);
    k = 0;
    while (!(!bus.acia_n_rd && bus.acia_regSel) && k < 200) begin tick(); k++; end
    check("mid_read_timeout", {31'b0, (!bus.acia_n_rd && bus.acia_regSel)}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_n_rd", {31'b0, bus.acia_n_rd}, 32'd1);
    check("mid_rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("mid_rst_init_done", {31'b0, bus.init_done}, 32'd0);

    // Preload rx and tx for the tie test, then rerun init
    for (int i = 0; i < 4; i++) push_rx(8'(8'h10 + i));
    bus.rx_ready = 1'b1;
    tx_bit = 1'b1;
    bus.tx_data = 8'h20;
    bus.tx_valid = 1'b1;
    tick();
    base = ev_cnt;
    release_and_check_init("reinit");

    idx = 0;
    seen = 1'b0;
    k = 0;
    while (ev_cnt - base < 8 && k < 400) begin
      if (seen) begin idx++; seen = 1'b0; end
      bus.tx_valid = (idx < 4);
      bus.tx_data = 8'(8'h20 + idx);
      #2;
      if (bus.tx_valid && bus.tx_ready) seen = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    bus.tx_valid = 1'b0;
    check("tie_events", ev_cnt - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tie_dir%0d", i), {31'b0, ev_dir[8'(base + i)]}, {31'b0, i[0]});
      check($sformatf("tie_byte%0d", i), {24'b0, ev_byte[8'(base + i)]},
            (i % 2 == 0) ? 32'h10 + i / 2 : 32'h20 + i / 2);
    end

    // Randomised traffic against the stream-level model
    repeat (20) tick();
    wr_chk = wr_cnt;
    for (int c = 0; c < 3000; c++) rand_step(1'b0);
    for (int c = 0; c < 600; c++) rand_step(1'b1);
    check("rand_rx_left", exp_rx.size(), 32'd0);
    check("rand_tx_left", exp_tx.size(), 32'd0);

`ifdef ACIA_HOST_IRQ_EN
    bus.rx_ready = 1'b1;
    repeat (30) tick();
    base = strobe_cnt;
    repeat (1000) tick();
    check("irq_quiet", strobe_cnt - base, 32'd0);
    push_rx(8'h77);
    k = 0;
    while (bus.acia_n_rd && k < 10) begin tick(); k++; end
    check("irq_latency", {31'b0, (k <= 4)}, 32'd1);
    repeat (40) tick();
`endif

    check("protocol", viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
